// File: rtl/add_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : add_rr_scheduler
// Purpose  : Round-robin scheduler that shares one signed two-input adder
//            among NUM_CH channels. Each channel owns an A FIFO, a B FIFO
//            (both first-word-fall-through) and an output FIFO. A ready
//            channel is granted, its A and B heads are popped together, the
//            sum is registered and pushed to that channel's output FIFO on
//            the following cycle. One sum every two cycles.
//
// Parameters
//   NUM_CH      number of channels sharing the adder (2..8, 1 allowed)
//   DATA_WIDTH  signed sample width of A, B and the sum
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   asynchronous, active-low reset
//   ch_en       in   per-channel enable (0 = never granted)
//   inA_empty   in   A FIFO empty flags
//   inA_dout    in   A FIFO heads, channel c at [c*DW +: DW]
//   inA_rd_en   out  A FIFO pops, one-hot or zero
//   inB_empty   in   B FIFO empty flags
//   inB_dout    in   B FIFO heads, same packing as A
//   inB_rd_en   out  B FIFO pops, always equal to inA_rd_en
//   out_full    in   output FIFO full flags
//   out_wr_en   out  output FIFO pushes, one-hot or zero
//   out_din     out  sum, broadcast to every output FIFO
//   busy        out  high while the push cycle is in progress
//
// Configuration macro
//   ADD_RR_SCHEDULER_SAT_EN  defined   : sum saturates on signed overflow
//                            undefined : sum wraps modulo 2^DATA_WIDTH
//
// Revision : 1.0  initial release
// ============================================================================
module add_rr_scheduler #(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            ch_en,
  input  logic [NUM_CH-1:0]            inA_empty,
  input  logic [NUM_CH*DATA_WIDTH-1:0] inA_dout,
  output logic [NUM_CH-1:0]            inA_rd_en,
  input  logic [NUM_CH-1:0]            inB_empty,
  input  logic [NUM_CH*DATA_WIDTH-1:0] inB_dout,
  output logic [NUM_CH-1:0]            inB_rd_en,
  input  logic [NUM_CH-1:0]            out_full,
  output logic [NUM_CH-1:0]            out_wr_en,
  output logic [DATA_WIDTH-1:0]        out_din,
  output logic                         busy
);

  // Channel index width; a single channel still needs a 1-bit index.
  localparam int PW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // One extra bit so rr_ptr + offset (< 2*NUM_CH) never overflows.
  localparam int PW1 = PW + 1;
  localparam logic [PW-1:0]  LAST_CH  = PW'(NUM_CH - 1);
  localparam logic [PW1-1:0] NUM_CH_W = PW1'(NUM_CH);

  typedef enum logic [0:0] {
    S_ARB   = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic [PW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]           gnt_q, gnt_d;
  logic [DATA_WIDTH-1:0]   sum_q, sum_d;

  // --------------------------------------------------------------------------
  // Arbitration and datapath wires
  // --------------------------------------------------------------------------
  logic [NUM_CH-1:0]       ready;
  logic [PW1-1:0]          cand;
  logic [PW-1:0]           pick;
  logic                    found;
  logic                    grant;
  logic [DATA_WIDTH-1:0]   a_sel;
  logic [DATA_WIDTH-1:0]   b_sel;
  logic [DATA_WIDTH-1:0]   sum_calc;

  // A channel is only eligible when both operands are present and the
  // result has somewhere to go; checking fullness here is what lets the
  // push cycle proceed unconditionally later.
  assign ready = ch_en & ~inA_empty & ~inB_empty & ~out_full;

  // Rotating priority search starting one past the last granted channel.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = {1'b0, rr_ptr_q} + PW1'(i);
      if (cand >= NUM_CH_W) begin
        cand = cand - NUM_CH_W;
      end
      if (!found && ready[cand[PW-1:0]]) begin
        found = 1'b1;
        pick  = cand[PW-1:0];
      end
    end
  end

  // Pops are combinational from registered state and inputs. They are also
  // gated by reset so nothing is popped while the block is held in reset.
  assign grant = reset && (state_q == S_ARB) && found;

  // Operand selection for the picked channel.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (pick == PW'(c)) begin
        a_sel = inA_dout[c*DATA_WIDTH +: DATA_WIDTH];
        b_sel = inB_dout[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef ADD_RR_SCHEDULER_SAT_EN
  // Sign-extend by one bit; overflow shows up as the top two bits differing.
  logic [DATA_WIDTH:0] sum_ext;

  always_comb begin
    sum_ext = {a_sel[DATA_WIDTH-1], a_sel} + {b_sel[DATA_WIDTH-1], b_sel};
    if (sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1]) begin
      if (sum_ext[DATA_WIDTH]) begin
        sum_calc = {1'b1, {(DATA_WIDTH-1){1'b0}}};   // most negative
      end else begin
        sum_calc = {1'b0, {(DATA_WIDTH-1){1'b1}}};   // most positive
      end
    end else begin
      sum_calc = sum_ext[DATA_WIDTH-1:0];
    end
  end
`else
  // Two's-complement wrap: simply keep the low DATA_WIDTH bits.
  always_comb begin
    sum_calc = a_sel + b_sel;
  end
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_ARB;
      rr_ptr_q <= LAST_CH;        // channel 0 searched first after reset
      gnt_q    <= '0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      sum_q    <= sum_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    sum_d    = sum_q;
    case (state_q)
      S_ARB: begin
        if (grant) begin
          state_d  = S_WRITE;
          rr_ptr_d = pick;
          gnt_d    = pick;
          sum_d    = sum_calc;
        end
      end
      S_WRITE: begin
        // The push happens this cycle regardless of input changes.
        state_d = S_ARB;
      end
      default: begin
        state_d = S_ARB;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign inA_rd_en[c] = grant && (pick == PW'(c));
    assign out_wr_en[c] = (state_q == S_WRITE) && (gnt_q == PW'(c));
  end

  assign inB_rd_en = inA_rd_en;

  // sum_q only changes on a grant edge, so driving out_din straight from it
  // both presents the new sum in the push cycle and holds it afterwards.
  assign out_din = sum_q;
  assign busy    = (state_q == S_WRITE);

endmodule
`default_nettype wire
